// File: rtl/code_entry_pkg.sv
// Shared types and constants for the keypad code-entry controller:
// key class codes, FSM state encoding and the external game_status encoding.
package code_entry_pkg;

    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_IDLE  = 4'hF;

    localparam logic [1:0] GS_ENTRY   = 2'b00;
    localparam logic [1:0] GS_GRANTED = 2'b01;
    localparam logic [1:0] GS_DENIED  = 2'b10;
    localparam logic [1:0] GS_LOCKED  = 2'b11;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_GRANTED,
        ST_DENIED,
        ST_LOCKED,
        ST_CHECK
    } state_t;

    // CHECK lasts one cycle and is reported to the outside world as ENTRY.
    function automatic logic [1:0] status_of(state_t s);
        case (s)
            ST_GRANTED: status_of = GS_GRANTED;
            ST_DENIED:  status_of = GS_DENIED;
            ST_LOCKED:  status_of = GS_LOCKED;
            default:    status_of = GS_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/code_entry_if.sv
// Bus between the keypad/secret source (master) and code_entry_ctrl (slave).
// Parameters must match the ones given to code_entry_ctrl.
interface code_entry_if #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int MAX_ATTEMPTS = 3
);
    logic [DIGIT_W-1:0]                  key_code;
    logic [NUM_DIGITS*DIGIT_W-1:0]       secret_code;
    logic                                secret_valid;
    logic [NUM_DIGITS*DIGIT_W-1:0]       entered_code;
    logic [$clog2(NUM_DIGITS+1)-1:0]     digit_count;
    logic                                code_entered;
    logic [1:0]                          game_status;
    logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left;
    logic                                match_pulse;

    modport master (
        output key_code, secret_code, secret_valid,
        input  entered_code, digit_count, code_entered, game_status, attempts_left, match_pulse
    );

    modport slave (
        input  key_code, secret_code, secret_valid,
        output entered_code, digit_count, code_entered, game_status, attempts_left, match_pulse
    );

endinterface

// File: rtl/key_debounce.sv
// Debounce and edge-detect for keypad decoder codes: one key_valid pulse per stable press,
// re-armed only after the idle code has been stable for the same window.
module key_debounce #(
    parameter int DIGIT_W         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clock_100Mhz,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] key_code,
    output logic               key_valid,
    output logic [DIGIT_W-1:0] key_value
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] WINDOW = CNT_W'(DEBOUNCE_CYCLES);

    logic [DIGIT_W-1:0] last_key;
    logic [CNT_W-1:0]   stable_cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic               armed;
    logic               changed;
    logic               window_done;

    assign changed     = (key_code != last_key);
    assign next_cnt    = changed ? CNT_W'(1) :
                         (stable_cnt == WINDOW) ? stable_cnt : stable_cnt + 1'b1;
    // Fires once, on the cycle the current value completes its window.
    assign window_done = (next_cnt == WINDOW) && (changed || stable_cnt != WINDOW);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_100Mhz) begin
        if (!reset) begin
            last_key   <= '1;
            stable_cnt <= '0;
            armed      <= 1'b1;
            key_valid  <= 1'b0;
            key_value  <= '1;
        end else begin
            last_key   <= key_code;
            stable_cnt <= next_cnt;
            key_valid  <= 1'b0;
            if (window_done) begin
                if (key_code == '1) begin
                    armed <= 1'b1;
                end else if (armed) begin
                    armed     <= 1'b0;
                    key_valid <= 1'b1;
                    key_value <= key_code;
                end
            end
        end
    end

endmodule

// File: rtl/code_entry_ctrl.sv
// Keypad code-entry controller: digit buffer, submit/compare, attempt counter and lockout timer.
// Define AUTO_SUBMIT_EN to submit automatically when the last digit of the code is entered.
module code_entry_ctrl
    import code_entry_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int DIGIT_W         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_ATTEMPTS    = 3,
    parameter int LOCKOUT_CYCLES  = 500_000_000
) (
    input  logic         clock_100Mhz,
    input  logic         reset,
    code_entry_if.slave  bus
);

    localparam int BUF_W = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int LT_W  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]   FULL      = CNT_W'(NUM_DIGITS);
    localparam logic [ATT_W-1:0]   ATT_MAX   = ATT_W'(MAX_ATTEMPTS);
    localparam logic [LT_W-1:0]    LOCK_LOAD = LT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [DIGIT_W-1:0] K_BKSP    = DIGIT_W'(KEY_BKSP);
    localparam logic [DIGIT_W-1:0] K_CLR     = DIGIT_W'(KEY_CLR);
    localparam logic [DIGIT_W-1:0] K_ENTER   = DIGIT_W'(KEY_ENTER);

    state_t             state, state_n;
    logic [BUF_W-1:0]   buffer, buffer_n, shifted;
    logic [CNT_W-1:0]   count, count_n;
    logic [ATT_W-1:0]   attempts, attempts_n, att_dec;
    logic [LT_W-1:0]    lock_timer, lock_timer_n;
    logic               match_q, match_n;
    logic               key_valid;
    logic [DIGIT_W-1:0] key_value;

    key_debounce #(
        .DIGIT_W         (DIGIT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .key_code     (bus.key_code),
        .key_valid    (key_valid),
        .key_value    (key_value)
    );

    assign shifted = BUF_W'({buffer, key_value});
    assign att_dec = (attempts == '0) ? '0 : attempts - 1'b1;

    always_ff @(posedge clock_100Mhz) begin
        if (!reset) begin
            state      <= ST_ENTRY;
            buffer     <= '0;
            count      <= '0;
            attempts   <= ATT_MAX;
            lock_timer <= '0;
            match_q    <= 1'b0;
        end else begin
            state      <= state_n;
            buffer     <= buffer_n;
            count      <= count_n;
            attempts   <= attempts_n;
            lock_timer <= lock_timer_n;
            match_q    <= match_n;
        end
    end

    // NOTE: every next-state variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_n      = state;
        buffer_n     = buffer;
        count_n      = count;
        attempts_n   = attempts;
        lock_timer_n = lock_timer;
        match_n      = 1'b0;
        case (state)
            ST_ENTRY: if (key_valid) begin
                case (key_value)
                    K_BKSP: if (count != '0) begin
                        buffer_n = buffer >> DIGIT_W;
                        count_n  = count - 1'b1;
                    end
                    K_CLR: begin
                        buffer_n = '0;
                        count_n  = '0;
                    end
                    K_ENTER: if (count == FULL && bus.secret_valid) state_n = ST_CHECK;
                    default: if (count != FULL) begin
                        buffer_n = shifted;
                        count_n  = count + 1'b1;
`ifdef AUTO_SUBMIT_EN
                        if (count_n == FULL && bus.secret_valid) state_n = ST_CHECK;
`endif
                    end
                endcase
            end
            ST_CHECK: begin
                if (buffer == bus.secret_code) begin
                    state_n = ST_GRANTED;
                    match_n = 1'b1;
                end else begin
                    attempts_n = att_dec;
                    if (att_dec == '0) begin
                        state_n      = ST_LOCKED;
                        lock_timer_n = LOCK_LOAD;
                    end else begin
                        state_n = ST_DENIED;
                    end
                end
            end
            ST_GRANTED: if (key_valid && key_value == K_CLR) begin
                state_n    = ST_ENTRY;
                buffer_n   = '0;
                count_n    = '0;
                attempts_n = ATT_MAX;
            end
            ST_DENIED: if (key_valid) begin
                state_n  = ST_ENTRY;
                buffer_n = '0;
                count_n  = '0;
            end
            ST_LOCKED: begin
                if (lock_timer == '0) begin
                    state_n    = ST_ENTRY;
                    buffer_n   = '0;
                    count_n    = '0;
                    attempts_n = ATT_MAX;
                end else begin
                    lock_timer_n = lock_timer - 1'b1;
                end
            end
            default: state_n = ST_ENTRY;
        endcase
    end

    assign bus.entered_code  = buffer;
    assign bus.digit_count   = count;
    assign bus.code_entered  = (count == FULL);
    assign bus.game_status   = status_of(state);
    assign bus.attempts_left = attempts;
    assign bus.match_pulse   = match_q;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl with a short debounce window and lockout (secret 16'h1234).
// Covers the default build; the AUTO_SUBMIT_EN build swaps the vector table for an auto-submit sequence.
module tb_code_entry_ctrl;

    logic clock_100Mhz = 1'b0;
    logic reset        = 1'b0;
    int   checks       = 0;
    int   errors       = 0;
    int   match_cnt    = 0;

    always #5 clock_100Mhz = ~clock_100Mhz;

    code_entry_if #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(3)) bus ();

    code_entry_ctrl #(
        .NUM_DIGITS      (4),
        .DIGIT_W         (4),
        .DEBOUNCE_CYCLES (2),
        .MAX_ATTEMPTS    (3),
        .LOCKOUT_CYCLES  (8)
    ) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .bus          (bus)
    );

    always @(negedge clock_100Mhz) if (bus.match_pulse === 1'b1) match_cnt++;

    typedef struct {
        logic [3:0]  key;
        logic        sv;
        logic [15:0] code;
        int          cnt;
        logic [1:0]  st;
        int          att;
    } vec_t;

    vec_t tbl [18];

    task automatic step(input int n);
        repeat (n) @(negedge clock_100Mhz);
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_code = k;
        step(3);
        bus.key_code = 4'hF;
        step(3);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] code, input int cnt,
                                 input logic [1:0] st, input int att);
        check({tag, " entered_code"},  32'(bus.entered_code),  32'(code));
        check({tag, " digit_count"},   32'(bus.digit_count),   32'(cnt));
        check({tag, " code_entered"},  32'(bus.code_entered),  32'(cnt == 4));
        check({tag, " game_status"},   32'(bus.game_status),   32'(st));
        check({tag, " attempts_left"}, 32'(bus.attempts_left), 32'(att));
    endtask

    task automatic check_reset(input string tag);
        check_outputs(tag, 16'h0000, 0, 2'b00, 3);
        check({tag, " match_pulse"}, 32'(bus.match_pulse), 32'd0);
    endtask

    initial begin
        int n;
        int locked;
        bus.key_code     = 4'hF;
        bus.secret_code  = 16'h1234;
        bus.secret_valid = 1'b1;
        step(3);
        check_reset("reset");
        reset = 1'b1;
        step(2);

`ifdef AUTO_SUBMIT_EN
        press(4'h1); press(4'h2); press(4'h3);
        check_outputs("auto 3 digits", 16'h0123, 3, 2'b00, 3);
        press(4'h4);
        check_outputs("auto 4th digit", 16'h1234, 4, 2'b01, 3);
        check("auto match_pulse count", 32'(match_cnt), 32'd1);
        press(4'hC);
        check_outputs("auto clr", 16'h0000, 0, 2'b00, 3);
`else
        tbl[0]  = '{4'h1, 1'b1, 16'h0001, 1, 2'b00, 3};
        tbl[1]  = '{4'h2, 1'b1, 16'h0012, 2, 2'b00, 3};
        tbl[2]  = '{4'h3, 1'b1, 16'h0123, 3, 2'b00, 3};
        tbl[3]  = '{4'hE, 1'b1, 16'h0123, 3, 2'b00, 3};
        tbl[4]  = '{4'h9, 1'b1, 16'h1239, 4, 2'b00, 3};
        tbl[5]  = '{4'h5, 1'b1, 16'h1239, 4, 2'b00, 3};
        tbl[6]  = '{4'hB, 1'b1, 16'h0123, 3, 2'b00, 3};
        tbl[7]  = '{4'h4, 1'b1, 16'h1234, 4, 2'b00, 3};
        tbl[8]  = '{4'hE, 1'b1, 16'h1234, 4, 2'b01, 3};
        tbl[9]  = '{4'h5, 1'b1, 16'h1234, 4, 2'b01, 3};
        tbl[10] = '{4'hC, 1'b1, 16'h0000, 0, 2'b00, 3};
        tbl[11] = '{4'h0, 1'b1, 16'h0000, 1, 2'b00, 3};
        tbl[12] = '{4'h0, 1'b1, 16'h0000, 2, 2'b00, 3};
        tbl[13] = '{4'h0, 1'b1, 16'h0000, 3, 2'b00, 3};
        tbl[14] = '{4'h0, 1'b0, 16'h0000, 4, 2'b00, 3};
        tbl[15] = '{4'hE, 1'b0, 16'h0000, 4, 2'b00, 3};
        tbl[16] = '{4'hE, 1'b1, 16'h0000, 4, 2'b10, 2};
        tbl[17] = '{4'h7, 1'b1, 16'h0000, 0, 2'b00, 2};
        for (int i = 0; i < 18; i++) begin
            bus.secret_valid = tbl[i].sv;
            press(tbl[i].key);
            check_outputs($sformatf("vec%0d", i), tbl[i].code, tbl[i].cnt, tbl[i].st, tbl[i].att);
        end
        check("match_pulse count", 32'(match_cnt), 32'd1);

        // A long hold stores one digit; a one-cycle glitch stores nothing.
        bus.key_code = 4'h5;
        step(50);
        bus.key_code = 4'hF;
        step(5);
        check_outputs("hold 5", 16'h0005, 1, 2'b00, 2);
        bus.key_code = 4'h7;
        step(1);
        bus.key_code = 4'hF;
        step(5);
        check_outputs("glitch", 16'h0005, 1, 2'b00, 2);

        press(4'hC);
        repeat (4) press(4'h0);
        press(4'hE);
        check_outputs("deny 2", 16'h0000, 4, 2'b10, 1);
        press(4'h1);
        repeat (4) press(4'h0);
        bus.key_code = 4'hE;
        n = 0;
        while (bus.game_status !== 2'b11 && n < 20) begin
            step(1);
            n++;
        end
        check("lock entry", 32'(bus.game_status), 32'h3);
        check("lock attempts", 32'(bus.attempts_left), 32'd0);
        bus.key_code = 4'h3;
        locked = 0;
        n = 0;
        while (bus.game_status === 2'b11 && n < 30) begin
            locked++;
            step(1);
            n++;
        end
        check("lock duration", 32'(locked), 32'd8);
        check_outputs("unlock", 16'h0000, 0, 2'b00, 3);
        bus.key_code = 4'hF;
        step(5);
        check_outputs("after unlock", 16'h0000, 0, 2'b00, 3);
`endif

        // Exhaust attempts again and hit reset while LOCKED.
        for (int r = 0; r < 3; r++) begin
            repeat (4) press(4'h0);
`ifndef AUTO_SUBMIT_EN
            press(4'hE);
`endif
            if (bus.game_status === 2'b10) press(4'h1);
        end
        check("relock status", 32'(bus.game_status), 32'h3);
        reset = 1'b0;
        step(1);
        check_reset("reset in lock");
        reset = 1'b1;
        step(2);

        // Reset while a key is part-way through its debounce window.
        bus.key_code = 4'h8;
        step(1);
        reset = 1'b0;
        step(1);
        check_reset("reset mid-debounce");
        bus.key_code = 4'hF;
        reset = 1'b1;
        step(6);
        check_reset("after mid-debounce");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
